// File: rtl/eh2_pkg.sv
// ============================================================================
// Module : eh2_pkg
// Brief  : Shared types for the LSU halt sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef NUM_THREADS
`define NUM_THREADS 2
`endif

package eh2_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    BLOCK  = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3,
    WAKE   = 3'd4
  } eh2_lsu_halt_state_e;

endpackage

`default_nettype wire

// File: rtl/eh2_lsu_halt_seq_thr.sv
// ============================================================================
// Module : eh2_lsu_halt_seq_thr
// Brief  : One thread's halt FSM, drain timeout counter and bus-idle sample.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module eh2_lsu_halt_seq_thr
  import eh2_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clk_override,
  input  logic halt_req,
  input  logic force_halt,
  input  logic pipe_idle,
  input  logic stbuf_empty,
  input  logic bus_buffer_empty,
  input  logic bus_idle,
  input  logic bus_clk_en,
  output logic block_issue,
  output logic halt_ack,
  output logic thread_clken,
  output logic halt_timeout
);

  localparam logic [TIMEOUT_W-1:0] C_CNT_MAX = '1;

  eh2_lsu_halt_state_e r_state;
  eh2_lsu_halt_state_e w_state_nxt;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_bus_idle_q;
  logic                 w_drained;
  logic                 w_timed_out;

  assign w_drained   = stbuf_empty & bus_buffer_empty & r_bus_idle_q;
  assign w_timed_out = (r_state == DRAIN) && (r_cnt == C_CNT_MAX);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The counter only lives while the FSM stays in DRAIN; DRAIN always exits at max, so it never wraps.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt        <= '0;
      r_bus_idle_q <= 1'b0;
    end else begin
      if ((r_state == DRAIN) && (w_state_nxt == DRAIN)) begin
        r_cnt <= r_cnt + TIMEOUT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (bus_clk_en) begin
        r_bus_idle_q <= bus_idle;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (force_halt && (r_state != HALTED)) begin
      w_state_nxt = HALTED;
    end else begin
      case (r_state)
        RUN: begin
          if (halt_req) w_state_nxt = BLOCK;
        end
        BLOCK: begin
          if (!halt_req)      w_state_nxt = RUN;
          else if (pipe_idle) w_state_nxt = DRAIN;
        end
        DRAIN: begin
          if (!halt_req)                     w_state_nxt = RUN;
          else if (w_drained || w_timed_out) w_state_nxt = HALTED;
        end
        HALTED: begin
          if (!halt_req && !force_halt) w_state_nxt = WAKE;
        end
        WAKE: begin
          w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // WAKE restarts the clock one cycle before issue is unblocked.
  always_comb begin
    block_issue  = (r_state != RUN);
    halt_ack     = (r_state == HALTED);
    thread_clken = clk_override | (r_state != HALTED);
    halt_timeout = w_timed_out;
  end

endmodule

`default_nettype wire

// File: rtl/eh2_lsu_halt_seq.sv
// ============================================================================
// Module : eh2_lsu_halt_seq
// Brief  : Per-thread LSU halt/drain sequencer, one independent FSM per thread.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef NUM_THREADS
`define NUM_THREADS 2
`endif

module eh2_lsu_halt_seq
  import eh2_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    clk_override,
  input  logic [`NUM_THREADS-1:0] halt_req,
  input  logic [`NUM_THREADS-1:0] dec_tlu_force_halt,
  input  logic [`NUM_THREADS-1:0] lsu_pipe_idle,
  input  logic [`NUM_THREADS-1:0] lsu_stbuf_empty_any,
  input  logic [`NUM_THREADS-1:0] lsu_bus_buffer_empty_any,
  input  logic [`NUM_THREADS-1:0] lsu_bus_idle_any,
  input  logic                    lsu_bus_clk_en,
  output logic [`NUM_THREADS-1:0] lsu_halt_block_issue,
  output logic [`NUM_THREADS-1:0] lsu_halt_ack,
  output logic [`NUM_THREADS-1:0] lsu_thread_clken,
  output logic [`NUM_THREADS-1:0] lsu_halt_timeout
);

  for (genvar i = 0; i < `NUM_THREADS; i++) begin : g_thr
    eh2_lsu_halt_seq_thr #(
      .TIMEOUT_W (TIMEOUT_W)
    ) u_thr (
      .clk              (clk),
      .rst_l            (rst_l),
      .clk_override     (clk_override),
      .halt_req         (halt_req[i]),
      .force_halt       (dec_tlu_force_halt[i]),
      .pipe_idle        (lsu_pipe_idle[i]),
      .stbuf_empty      (lsu_stbuf_empty_any[i]),
      .bus_buffer_empty (lsu_bus_buffer_empty_any[i]),
      .bus_idle         (lsu_bus_idle_any[i]),
      .bus_clk_en       (lsu_bus_clk_en),
      .block_issue      (lsu_halt_block_issue[i]),
      .halt_ack         (lsu_halt_ack[i]),
      .thread_clken     (lsu_thread_clken[i]),
      .halt_timeout     (lsu_halt_timeout[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_eh2_lsu_halt_seq.sv
// Testbench for eh2_lsu_halt_seq: cycle model compared every negedge plus directed literal checks.
`ifndef NUM_THREADS
`define NUM_THREADS 2
`endif

module tb_eh2_lsu_halt_seq;

  localparam int NT   = `NUM_THREADS;
  localparam int TW   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          clk_override = 1'b0;
  logic [NT-1:0] halt_req = '0;
  logic [NT-1:0] force_halt = '0;
  logic [NT-1:0] pipe_idle = '1;
  logic [NT-1:0] stbuf = '1;
  logic [NT-1:0] busbuf = '1;
  logic [NT-1:0] bus_idle = '1;
  logic          bus_clk_en = 1'b1;
  logic [NT-1:0] block, ack, clken, tmo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  eh2_lsu_halt_seq #(.TIMEOUT_W(TW)) dut (
    .clk                      (clk),
    .rst_l                    (rst_l),
    .clk_override             (clk_override),
    .halt_req                 (halt_req),
    .dec_tlu_force_halt       (force_halt),
    .lsu_pipe_idle            (pipe_idle),
    .lsu_stbuf_empty_any      (stbuf),
    .lsu_bus_buffer_empty_any (busbuf),
    .lsu_bus_idle_any         (bus_idle),
    .lsu_bus_clk_en           (bus_clk_en),
    .lsu_halt_block_issue     (block),
    .lsu_halt_ack             (ack),
    .lsu_thread_clken         (clken),
    .lsu_halt_timeout         (tmo)
  );

  task automatic check(input string nm, input logic [NT-1:0] act, input logic [NT-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: mode 0=run 1=blocked 2=draining 3=halted 4=waking; drain age from a cycle stamp.
  int m_mode  [NT];
  int m_start [NT];
  bit m_busq  [NT];
  int cyc = 0;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NT; i++) begin
        m_mode[i] = 0;
        m_busq[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        automatic bit done = stbuf[i] && busbuf[i] && m_busq[i];
        automatic bit tout = (m_mode[i] == 2) && ((cyc - m_start[i]) == TMAX);
        automatic int nm   = m_mode[i];
        if (force_halt[i] && m_mode[i] != 3) nm = 3;
        else if (m_mode[i] == 0) nm = halt_req[i] ? 1 : 0;
        else if (m_mode[i] == 1) nm = !halt_req[i] ? 0 : (pipe_idle[i] ? 2 : 1);
        else if (m_mode[i] == 2) nm = !halt_req[i] ? 0 : ((done || tout) ? 3 : 2);
        else if (m_mode[i] == 3) nm = (!halt_req[i] && !force_halt[i]) ? 4 : 3;
        else nm = 0;
        if (nm == 2 && m_mode[i] != 2) m_start[i] = cyc + 1;
        m_mode[i] = nm;
        if (bus_clk_en) m_busq[i] = bus_idle[i];
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [NT-1:0] eb, ea, ec, et;
    for (int i = 0; i < NT; i++) begin
      eb[i] = (m_mode[i] != 0);
      ea[i] = (m_mode[i] == 3);
      ec[i] = clk_override || (m_mode[i] != 3);
      et[i] = (m_mode[i] == 2) && ((cyc - m_start[i]) == TMAX);
    end
    check("model_block", block, eb);
    check("model_ack",   ack,   ea);
    check("model_clken", clken, ec);
    check("model_tmo",   tmo,   et);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_block", block, 2'b00);
    check("rst_ack",   ack,   2'b00);
    check("rst_clken", clken, 2'b11);
    check("rst_tmo",   tmo,   2'b00);
    tick(2);
    rst_l = 1'b1;
    tick(1);

    // Graceful halt with everything already empty
    halt_req = 2'b01;
    tick(1); check("s1_block_c1", block, 2'b01);
    tick(1); check("s1_drain_ack", ack, 2'b00);
    tick(1); check("s1_ack_c3", ack, 2'b01);
             check("s1_clken_c3", clken, 2'b10);

    // Clock override while halted, then wake
    clk_override = 1'b1;
    #1; check("ovr_clken", clken, 2'b11);
        check("ovr_ack", ack, 2'b01);
    clk_override = 1'b0;
    halt_req = 2'b00;
    tick(1); check("wake_block", block, 2'b01);
             check("wake_clken", clken, 2'b11);
             check("wake_ack", ack, 2'b00);
    tick(1); check("run_block", block, 2'b00);

    // Drain timeout
    stbuf = 2'b10;
    halt_req = 2'b01;
    tick(2);
    tick(14); check("to_early", tmo, 2'b00);
    tick(1);  check("to_pulse", tmo, 2'b01);
              check("to_noack", ack, 2'b00);
    tick(1);  check("to_gone", tmo, 2'b00);
              check("to_ack", ack, 2'b01);
    halt_req = 2'b00;
    stbuf = 2'b11;
    tick(2);

    // Force halt on thread1 stuck in BLOCK
    pipe_idle = 2'b01;
    halt_req = 2'b10;
    tick(2); check("f_block", block, 2'b10);
    force_halt = 2'b10;
    tick(1); check("f_ack", ack, 2'b10);
             check("f_t0_block", block, 2'b10);
    force_halt = 2'b00;
    halt_req = 2'b00;
    pipe_idle = 2'b11;
    tick(2);

    // Bus idle only sampled on enabled cycles
    bus_idle = 2'b00;
    tick(1);
    halt_req = 2'b01;
    for (int k = 0; k < 8; k++) begin
      bus_clk_en = (k % 4 == 0);
      bus_idle = (k % 4 == 2) ? 2'b11 : 2'b00;
      tick(1);
    end
    check("bus_hold", ack, 2'b00);
    bus_idle = 2'b11;
    for (int k = 8; k < 28; k++) begin
      bus_clk_en = (k % 4 == 0);
      tick(1);
      if (ack[0]) break;
    end
    check("bus_ack", ack, 2'b01);
    bus_clk_en = 1'b1;
    halt_req = 2'b00;
    tick(2);

    // Async reset mid-drain
    stbuf = 2'b10;
    halt_req = 2'b01;
    tick(2);
    tick(9);
    rst_l = 1'b0;
    halt_req = 2'b00;
    #1;
    check("ar_block", block, 2'b00);
    check("ar_ack",   ack,   2'b00);
    check("ar_clken", clken, 2'b11);
    check("ar_tmo",   tmo,   2'b00);
    tick(2);
    rst_l = 1'b1;
    tick(1); check("ar_run", block, 2'b00);
    halt_req = 2'b01;
    tick(2);
    tick(14); check("ar_to_early", tmo, 2'b00);
    tick(1);  check("ar_to_pulse", tmo, 2'b01);
    halt_req = 2'b00;
    stbuf = 2'b11;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eh2_lsu_halt_seq.md
EH2_LSU_HALT_SEQ -- requirements
Module: eh2_lsu_halt_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 8: width of the per-thread drain timeout counter.
REQ-002 SHALL size every per-thread vector by `NUM_THREADS (NT); all vectors below are [NT-1:0].
REQ-003 SHALL have port clk  input  1  the one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst_l  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clk_override  input  1  forces all clock enables high.
REQ-006 SHALL have port halt_req  input  NT  per-thread graceful halt request (level).
REQ-007 SHALL have port dec_tlu_force_halt  input  NT  per-thread immediate halt (level).
REQ-008 SHALL have port lsu_pipe_idle  input  NT  no valid LSU packet of thread i in decode through dc5.
REQ-009 SHALL have port lsu_stbuf_empty_any  input  NT  store buffer holds no entry of thread i.
REQ-010 SHALL have port lsu_bus_buffer_empty_any  input  NT  bus buffer empty for thread i.
REQ-011 SHALL have port lsu_bus_idle_any  input  NT  bus interface idle for thread i (bus-clock domain).
REQ-012 SHALL have port lsu_bus_clk_en  input  1  bus clock enable; bus-domain inputs valid only when high.
REQ-013 SHALL have port lsu_halt_block_issue  output  NT  block new LSU issue for thread i.
REQ-014 SHALL have port lsu_halt_ack  output  NT  thread i is halted.
REQ-015 SHALL have port lsu_thread_clken  output  NT  enable for thread i clock header.
REQ-016 SHALL have port lsu_halt_timeout  output  NT  one-cycle pulse: drain timed out.

Function
REQ-017 SHALL run one independent FSM per thread with states RUN, BLOCK, DRAIN, HALTED, WAKE; all outputs registered (Moore).
REQ-018 RUN: block=0, ack=0, clken=1; halt_req[i]=1 -> BLOCK next cycle, so block rises one cycle after halt_req.
REQ-019 BLOCK: block=1; lsu_pipe_idle[i]=1 -> DRAIN; halt_req[i]=0 -> RUN.
REQ-020 SHALL keep bus_idle_q[i], loaded from lsu_bus_idle_any[i] only in cycles with lsu_bus_clk_en=1; reset value 0.
REQ-021 DRAIN: block=1; stbuf_empty & bus_buffer_empty & bus_idle_q all 1 -> HALTED; halt_req[i]=0 -> RUN.
REQ-022 DRAIN: counter increments every clk from 0; reaching 2^TIMEOUT_W-1 -> lsu_halt_timeout[i] high for exactly one cycle and -> HALTED.
REQ-023 Counter SHALL clear on every exit from DRAIN and never wrap.
REQ-024 HALTED: block=1, ack=1, clken=clk_override; halt_req[i]=0 and dec_tlu_force_halt[i]=0 -> WAKE.
REQ-025 WAKE: block=1, ack=0, clken=1 for exactly one cycle, then RUN (clock restarts before issue unblocks).
REQ-026 dec_tlu_force_halt[i]=1 SHALL move any state except HALTED to HALTED next cycle, with priority over halt_req and drain completion.
REQ-027 Drain completion and timeout in the same cycle SHALL take HALTED with timeout pulse asserted.
REQ-028 halt_req deassert and drain completion in the same DRAIN cycle SHALL go to RUN.
REQ-029 lsu_thread_clken[i] SHALL be forced 1 whenever clk_override=1, all states.
REQ-030 Threads SHALL not interact; one halting never stalls the other.

Reset
REQ-031 On rst_l low, asynchronously: all FSMs RUN, counters 0, bus_idle_q 0, block=0, ack=0, timeout=0, clken=1.
REQ-032 Reset mid-DRAIN or HALTED SHALL abandon the sequence; after release thread in RUN with no pending halt remembered.

Structure
REQ-033 eh2_lsu_halt_state_e (RUN, BLOCK, DRAIN, HALTED, WAKE) SHALL live in eh2_pkg.
REQ-034 Per-thread FSM, counter and bus_idle_q SHALL be sub-module eh2_lsu_halt_seq_thr, instantiated NT times in a generate loop.
REQ-035 All flops SHALL use the codebase async-reset flop primitives on clk; no internal clock gating.

Verification
REQ-036 Thread0 halt_req=1 at cycle 0, pipe_idle=1, all empties=1, bus_clk_en=1, bus_idle=1 -> block=1 at cycle 1, DRAIN cycle 2, ack=1 and clken=0 at cycle 3.
REQ-037 TIMEOUT_W=4, stbuf_empty[0] held 0 -> timeout pulse exactly once, 15 cycles after DRAIN entry, then ack=1.
REQ-038 In HALTED drop halt_req -> WAKE one cycle (clken=1, block=1), then RUN (block=0); clk_override=1 during HALTED -> clken=1, ack=1.
REQ-039 force_halt[1]=1 while thread1 in BLOCK with pipe_idle=0 -> HALTED next cycle; thread0 in RUN unaffected.
REQ-040 bus_clk_en=1 every 4th cycle, bus_idle toggled high between enables -> no DRAIN exit until an enabled sample sees 1.
REQ-041 Assert rst_l low while thread0 in DRAIN with counter=9 -> immediately block=0, ack=0, clken=1; after release counter=0, state RUN.
